wb_stage: RTL and testbench

- MEM/WB pipeline stage that drives the register file write port (`wregn`, `wdata`, `wen`).
- Captures the retiring instruction from the memory stage and selects the write-back source: ALU result, load data or link address.
- Extracts and sign/zero-extends sub-word loads and detects misaligned loads.
- Counts retired instructions.

---
 rtl/wb_stage.sv | 155 +++++++++++++++
 tb/tb_wb_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Purpose  : MEM/WB pipeline register driving the register-file write port,
//            with sub-word load extraction, misalignment detection and a
//            retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage #(
  parameter bit BIG_ENDIAN = 1'b1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_wen,
  input  logic [4:0]       in_wregn,
  input  logic [1:0]       in_wbsel,
  input  logic [2:0]       in_ldtype,
  input  logic [1:0]       in_addr_lo,
  input  logic [31:0]      in_alu,
  input  logic [31:0]      in_memdata,
  input  logic [31:0]      in_pc4,
  input  logic             stall,
  input  logic             flush,
  output logic [4:0]       wregn,
  output logic [31:0]      wdata,
  output logic             wen,
  output logic             wb_valid,
  output logic             misalign,
  output logic [CNT_W-1:0] instret
);

  localparam logic [1:0] c_WB_MEM  = 2'b01;
  localparam logic [1:0] c_WB_LINK = 2'b10;

  localparam logic [2:0] c_LD_LB  = 3'b001;
  localparam logic [2:0] c_LD_LBU = 3'b010;
  localparam logic [2:0] c_LD_LH  = 3'b011;
  localparam logic [2:0] c_LD_LHU = 3'b100;

  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]  w_byte_lane;
  logic        w_half_lane;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_wb_data;
  logic        w_is_byte;
  logic        w_is_half;
  logic        w_is_word;
  logic        w_misaligned;
  logic        w_load;
  logic        w_wen;

  logic [4:0]       wregn_q,    wregn_d;
  logic [31:0]      wdata_q,    wdata_d;
  logic             wen_q,      wen_d;
  logic             wb_valid_q, wb_valid_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] instret_q,  instret_d;

  // Lane index counts from bit 0 upward; big-endian offset 0 is the top lane.
  generate
    if (BIG_ENDIAN) begin : g_big_endian
      assign w_byte_lane = ~in_addr_lo;
      assign w_half_lane = ~in_addr_lo[1];
    end else begin : g_little_endian
      assign w_byte_lane = in_addr_lo;
      assign w_half_lane = in_addr_lo[1];
    end
  endgenerate

  assign w_byte = in_memdata[{w_byte_lane, 3'b000} +: 8];
  assign w_half = in_memdata[{w_half_lane, 4'b0000} +: 16];

  assign w_is_byte = (in_ldtype == c_LD_LB) || (in_ldtype == c_LD_LBU);
  assign w_is_half = (in_ldtype == c_LD_LH) || (in_ldtype == c_LD_LHU);
  assign w_is_word = ~w_is_byte & ~w_is_half;

  always_comb begin
    w_load_data = in_memdata;
    case (in_ldtype)
      c_LD_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
      c_LD_LBU: w_load_data = {24'h000000, w_byte};
      c_LD_LH:  w_load_data = {{16{w_half[15]}}, w_half};
      c_LD_LHU: w_load_data = {16'h0000, w_half};
      default:  w_load_data = in_memdata;
    endcase
  end

  always_comb begin
    w_wb_data = in_alu;
    case (in_wbsel)
      c_WB_MEM:  w_wb_data = w_load_data;
      c_WB_LINK: w_wb_data = in_pc4;
      default:   w_wb_data = in_alu;
    endcase
  end

  assign w_misaligned = (in_wbsel == c_WB_MEM) &
                        ((w_is_word & (in_addr_lo != 2'b00)) |
                         (w_is_half & in_addr_lo[0]));

  assign w_load = in_valid & ~stall & ~flush;
  // $0 is never reported as written so forwarding logic can ignore it.
  assign w_wen  = w_load & in_wen & (in_wregn != 5'd0) & ~w_misaligned;

  always_comb begin
    wregn_d    = wregn_q;
    wdata_d    = wdata_q;
    wen_d      = 1'b0;
    wb_valid_d = 1'b0;
    misalign_d = 1'b0;
    instret_d  = instret_q;
    if (w_load) begin
      wregn_d    = in_wregn;
      wdata_d    = w_wb_data;
      wen_d      = w_wen;
      wb_valid_d = 1'b1;
      misalign_d = w_misaligned;
      if (!w_misaligned) begin
        instret_d = instret_q + c_CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wregn_q    <= 5'd0;
      wdata_q    <= 32'd0;
      wen_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      instret_q  <= {CNT_W{1'b0}};
    end else begin
      wregn_q    <= wregn_d;
      wdata_q    <= wdata_d;
      wen_q      <= wen_d;
      wb_valid_q <= wb_valid_d;
      misalign_q <= misalign_d;
      instret_q  <= instret_d;
    end
  end

  assign wregn    = wregn_q;
  assign wdata    = wdata_q;
  assign wen      = wen_q;
  assign wb_valid = wb_valid_q;
  assign misalign = misalign_q;
  assign instret  = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage
// Purpose  : Directed self-checking bench for wb_stage (big/little endian and
//            narrow-counter instances sharing one stimulus stream).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_wen;
  logic [4:0]  in_wregn;
  logic [1:0]  in_wbsel;
  logic [2:0]  in_ldtype;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_alu;
  logic [31:0] in_memdata;
  logic [31:0] in_pc4;
  logic        stall;
  logic        flush;

  logic [4:0]  be_wregn,    le_wregn,    w4_wregn;
  logic [31:0] be_wdata,    le_wdata,    w4_wdata;
  logic        be_wen,      le_wen,      w4_wen;
  logic        be_wb_valid, le_wb_valid, w4_wb_valid;
  logic        be_misalign, le_misalign, w4_misalign;
  logic [31:0] be_instret,  le_instret;
  logic [3:0]  w4_instret;

  int n_checks;
  int n_fail;

  wb_stage #(.BIG_ENDIAN(1'b1), .CNT_W(32)) u_be (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_wen(in_wen),
    .in_wregn(in_wregn), .in_wbsel(in_wbsel), .in_ldtype(in_ldtype),
    .in_addr_lo(in_addr_lo), .in_alu(in_alu), .in_memdata(in_memdata),
    .in_pc4(in_pc4), .stall(stall), .flush(flush),
    .wregn(be_wregn), .wdata(be_wdata), .wen(be_wen), .wb_valid(be_wb_valid),
    .misalign(be_misalign), .instret(be_instret)
  );

  wb_stage #(.BIG_ENDIAN(1'b0), .CNT_W(32)) u_le (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_wen(in_wen),
    .in_wregn(in_wregn), .in_wbsel(in_wbsel), .in_ldtype(in_ldtype),
    .in_addr_lo(in_addr_lo), .in_alu(in_alu), .in_memdata(in_memdata),
    .in_pc4(in_pc4), .stall(stall), .flush(flush),
    .wregn(le_wregn), .wdata(le_wdata), .wen(le_wen), .wb_valid(le_wb_valid),
    .misalign(le_misalign), .instret(le_instret)
  );

  wb_stage #(.BIG_ENDIAN(1'b1), .CNT_W(4)) u_w4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_wen(in_wen),
    .in_wregn(in_wregn), .in_wbsel(in_wbsel), .in_ldtype(in_ldtype),
    .in_addr_lo(in_addr_lo), .in_alu(in_alu), .in_memdata(in_memdata),
    .in_pc4(in_pc4), .stall(stall), .flush(flush),
    .wregn(w4_wregn), .wdata(w4_wdata), .wen(w4_wen), .wb_valid(w4_wb_valid),
    .misalign(w4_misalign), .instret(w4_instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one instruction and advance past the capturing edge.
  task automatic issue(input logic v, input logic we, input logic [4:0] rn,
                       input logic [1:0] sel, input logic [2:0] ld,
                       input logic [1:0] lo, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [31:0] pc4);
    in_valid   = v;
    in_wen     = we;
    in_wregn   = rn;
    in_wbsel   = sel;
    in_ldtype  = ld;
    in_addr_lo = lo;
    in_alu     = alu;
    in_memdata = mem;
    in_pc4     = pc4;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;

    // Reset held with a valid instruction presented.
    issue(1'b1, 1'b1, 5'd5, 2'b00, 3'b000, 2'b00, 32'h11111111, 32'h0, 32'h0);
    issue(1'b1, 1'b1, 5'd5, 2'b00, 3'b000, 2'b00, 32'h11111111, 32'h0, 32'h0);
    chk("rst_wen",      {31'd0, be_wen},      32'd0);
    chk("rst_wb_valid", {31'd0, be_wb_valid}, 32'd0);
    chk("rst_misalign", {31'd0, be_misalign}, 32'd0);
    chk("rst_wregn",    {27'd0, be_wregn},    32'd0);
    chk("rst_wdata",    be_wdata,             32'd0);
    chk("rst_instret",  be_instret,           32'd0);

    reset = 1'b1;
    issue(1'b1, 1'b1, 5'd5, 2'b01, 3'b000, 2'b00, 32'h0, 32'hCAFEF00D, 32'h0);
    chk("lw_wen",     {31'd0, be_wen},   32'd1);
    chk("lw_wregn",   {27'd0, be_wregn}, 32'd5);
    chk("lw_wdata",   be_wdata,          32'hCAFEF00D);
    chk("lw_instret", be_instret,        32'd1);

    issue(1'b1, 1'b1, 5'd8, 2'b01, 3'b001, 2'b01, 32'h0, 32'h12F45678, 32'h0);
    chk("lb_be_wdata", be_wdata,        32'hFFFFFFF4);
    chk("lb_be_wen",   {31'd0, be_wen}, 32'd1);
    chk("lb_le_wdata", le_wdata,        32'h00000056);
    chk("lb_instret",  be_instret,      32'd2);

    issue(1'b1, 1'b1, 5'd8, 2'b01, 3'b010, 2'b01, 32'h0, 32'h12F45678, 32'h0);
    chk("lbu_be_wdata", be_wdata,   32'h000000F4);
    chk("lbu_instret",  be_instret, 32'd3);

    issue(1'b1, 1'b1, 5'd8, 2'b01, 3'b011, 2'b10, 32'h0, 32'h1234ABCD, 32'h0);
    chk("lh_be_wdata", be_wdata,   32'hFFFFABCD);
    chk("lh_le_wdata", le_wdata,   32'h00001234);
    chk("lh_instret",  be_instret, 32'd4);

    issue(1'b1, 1'b1, 5'd8, 2'b01, 3'b100, 2'b10, 32'h0, 32'h1234ABCD, 32'h0);
    chk("lhu_be_wdata", be_wdata,   32'h0000ABCD);
    chk("lhu_instret",  be_instret, 32'd5);

    issue(1'b1, 1'b1, 5'd9, 2'b01, 3'b000, 2'b01, 32'h0, 32'h1234ABCD, 32'h0);
    chk("mis_lw_wen",      {31'd0, be_wen},      32'd0);
    chk("mis_lw_misalign", {31'd0, be_misalign}, 32'd1);
    chk("mis_lw_valid",    {31'd0, be_wb_valid}, 32'd1);
    chk("mis_lw_instret",  be_instret,           32'd5);

    issue(1'b1, 1'b1, 5'd0, 2'b00, 3'b000, 2'b00, 32'hDEADBEEF, 32'h0, 32'h0);
    chk("r0_misalign", {31'd0, be_misalign}, 32'd0);
    chk("r0_wen",      {31'd0, be_wen},      32'd0);
    chk("r0_valid",    {31'd0, be_wb_valid}, 32'd1);
    chk("r0_wdata",    be_wdata,             32'hDEADBEEF);
    chk("r0_instret",  be_instret,           32'd6);

    issue(1'b1, 1'b1, 5'd31, 2'b10, 3'b000, 2'b00, 32'h0, 32'h0, 32'h00400010);
    chk("link_wdata",   be_wdata,          32'h00400010);
    chk("link_wregn",   {27'd0, be_wregn}, 32'd31);
    chk("link_wen",     {31'd0, be_wen},   32'd1);
    chk("link_instret", be_instret,        32'd7);

    issue(1'b1, 1'b1, 5'd4, 2'b01, 3'b011, 2'b11, 32'h0, 32'h1234ABCD, 32'h0);
    chk("mis_lh_misalign", {31'd0, be_misalign}, 32'd1);
    chk("mis_lh_wen",      {31'd0, be_wen},      32'd0);
    chk("mis_lh_instret",  be_instret,           32'd7);

    issue(1'b1, 1'b1, 5'd4, 2'b01, 3'b001, 2'b11, 32'h0, 32'h1234ABCD, 32'h0);
    chk("lb3_misalign", {31'd0, be_misalign}, 32'd0);
    chk("lb3_be_wdata", be_wdata,             32'hFFFFFFCD);
    chk("lb3_le_wdata", le_wdata,             32'h00000012);
    chk("lb3_instret",  be_instret,           32'd8);

    issue(1'b1, 1'b1, 5'd6, 2'b11, 3'b000, 2'b00, 32'h0BADF00D, 32'h55555555, 32'h66666666);
    chk("rsv_wdata",   be_wdata,   32'h0BADF00D);
    chk("rsv_instret", be_instret, 32'd9);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, 1'b1, 5'd7, 2'b00, 3'b000, 2'b00, 32'h77777777, 32'h0, 32'h0);
      chk("stall_wen",     {31'd0, be_wen},      32'd0);
      chk("stall_valid",   {31'd0, be_wb_valid}, 32'd0);
      chk("stall_instret", be_instret,           32'd9);
    end
    flush = 1'b1;
    issue(1'b1, 1'b1, 5'd7, 2'b00, 3'b000, 2'b00, 32'h77777777, 32'h0, 32'h0);
    chk("sf_valid",   {31'd0, be_wb_valid}, 32'd0);
    chk("sf_instret", be_instret,           32'd9);
    stall = 1'b0;
    issue(1'b1, 1'b1, 5'd7, 2'b00, 3'b000, 2'b00, 32'h77777777, 32'h0, 32'h0);
    chk("flush_wen",     {31'd0, be_wen},      32'd0);
    chk("flush_valid",   {31'd0, be_wb_valid}, 32'd0);
    chk("flush_instret", be_instret,           32'd9);
    flush = 1'b0;

    issue(1'b1, 1'b1, 5'd3, 2'b00, 3'b000, 2'b00, 32'h33333333, 32'h0, 32'h0);
    chk("pre_rst_wen", {31'd0, be_wen}, 32'd1);
    // In-flight instruction discarded by a mid-stream reset.
    reset = 1'b0;
    issue(1'b1, 1'b1, 5'd3, 2'b00, 3'b000, 2'b00, 32'h44444444, 32'h0, 32'h0);
    chk("mid_rst_wen",     {31'd0, be_wen}, 32'd0);
    chk("mid_rst_instret", be_instret,      32'd0);
    chk("mid_rst_w4",      {28'd0, w4_instret}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      issue(1'b1, 1'b0, 5'd2, 2'b00, 3'b000, 2'b00, i, 32'h0, 32'h0);
    end
    chk("w4_at15", {28'd0, w4_instret}, 32'd15);
    issue(1'b1, 1'b0, 5'd2, 2'b00, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0);
    chk("w4_wrap",     {28'd0, w4_instret}, 32'd0);
    chk("be_at16",     be_instret,          32'd16);
    chk("nowen_wen",   {31'd0, be_wen},     32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
